// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE MX slot buffer.
// Slot state is the pair {exp_valid, val_valid}, so the encoding doubles as the valid bits.
package redmule_pkg;

    typedef enum logic [1:0] {
        SLOT_EMPTY    = 2'b00,
        SLOT_VAL_ONLY = 2'b01,
        SLOT_EXP_ONLY = 2'b10,
        SLOT_FULL     = 2'b11
    } mx_slot_state_e;

    localparam int unsigned MX_X_EXP_W = 8;

endpackage

// File: rtl/redmule_mx_slot.sv
// One MX slot: a mantissa half and an exponent half that fill independently.
// REDMULE_MX_SLOT_REFILL_EN lets a consumed FULL slot accept new halves in the same cycle.
module redmule_mx_slot
    import redmule_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned EXP_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic              val_valid_i,
    output logic              val_ready_o,
    input  logic [DATA_W-1:0] val_data_i,
    input  logic              exp_valid_i,
    output logic              exp_ready_o,
    input  logic [EXP_W-1:0]  exp_data_i,
    output logic              slot_valid_o,
    output logic              slot_exp_valid_o,
    output logic [DATA_W-1:0] slot_data_o,
    output logic [EXP_W-1:0]  slot_exp_o,
    input  logic              consume_i,
    output logic              consume_err_o
);

    mx_slot_state_e    state_q;
    logic [DATA_W-1:0] data_q;
    logic [EXP_W-1:0]  exp_q;
    logic              err_q;

    logic full;
    logic consume_ok;
    logic val_fire;
    logic exp_fire;
    logic val_valid_d;
    logic exp_valid_d;

    always_comb begin
        full       = (state_q == SLOT_FULL);
        consume_ok = consume_i && full;
`ifdef REDMULE_MX_SLOT_REFILL_EN
        val_ready_o = rst_ni && enable_i && (!state_q[0] || consume_ok);
        exp_ready_o = rst_ni && enable_i && (!state_q[1] || consume_ok);
`else
        val_ready_o = rst_ni && enable_i && !state_q[0];
        exp_ready_o = rst_ni && enable_i && !state_q[1];
`endif
        val_fire    = val_valid_i && val_ready_o;
        exp_fire    = exp_valid_i && exp_ready_o;
        // A capture in the consume cycle overrides the clear of its own half.
        val_valid_d = val_fire || (state_q[0] && !consume_ok);
        exp_valid_d = exp_fire || (state_q[1] && !consume_ok);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= mx_slot_state_e'({exp_valid_d, val_valid_d});
            if (val_fire) data_q <= val_data_i;
            if (exp_fire) exp_q <= exp_data_i;
            if (consume_i && !full) err_q <= 1'b1;
        end
    end

    assign slot_valid_o     = state_q[0];
    assign slot_exp_valid_o = state_q[1];
    assign slot_data_o      = data_q;
    assign slot_exp_o       = exp_q;
    assign consume_err_o    = err_q;

endmodule

// File: rtl/redmule_mx_slot_buffer.sv
// X/W MX slot buffer feeding the arbiter: two independent slots plus a shared sticky consume error.
// REDMULE_MX_SLOT_REFILL_EN selects same-cycle refill after a consume.
module redmule_mx_slot_buffer
    import redmule_pkg::*;
#(
    parameter int unsigned MX_DATA_W       = 256,
    parameter int unsigned MX_EXP_VECTOR_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       mx_enable_i,
    input  logic                       x_val_valid_i,
    output logic                       x_val_ready_o,
    input  logic [MX_DATA_W-1:0]       x_val_data_i,
    input  logic                       x_exp_valid_i,
    output logic                       x_exp_ready_o,
    input  logic [MX_X_EXP_W-1:0]      x_exp_data_i,
    input  logic                       w_val_valid_i,
    output logic                       w_val_ready_o,
    input  logic [MX_DATA_W-1:0]       w_val_data_i,
    input  logic                       w_exp_valid_i,
    output logic                       w_exp_ready_o,
    input  logic [MX_EXP_VECTOR_W-1:0] w_exp_data_i,
    output logic                       x_slot_valid_o,
    output logic                       x_slot_exp_valid_o,
    output logic [MX_DATA_W-1:0]       x_slot_data_o,
    output logic [MX_X_EXP_W-1:0]      x_slot_exp_o,
    output logic                       w_slot_valid_o,
    output logic                       w_slot_exp_valid_o,
    output logic [MX_DATA_W-1:0]       w_slot_data_o,
    output logic [MX_EXP_VECTOR_W-1:0] w_slot_exp_o,
    input  logic                       consume_x_slot_i,
    input  logic                       consume_w_slot_i,
    output logic                       consume_err_o
);

    logic x_err;
    logic w_err;

    redmule_mx_slot #(
        .DATA_W (MX_DATA_W),
        .EXP_W  (MX_X_EXP_W)
    ) i_x_slot (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .enable_i         (mx_enable_i),
        .val_valid_i      (x_val_valid_i),
        .val_ready_o      (x_val_ready_o),
        .val_data_i       (x_val_data_i),
        .exp_valid_i      (x_exp_valid_i),
        .exp_ready_o      (x_exp_ready_o),
        .exp_data_i       (x_exp_data_i),
        .slot_valid_o     (x_slot_valid_o),
        .slot_exp_valid_o (x_slot_exp_valid_o),
        .slot_data_o      (x_slot_data_o),
        .slot_exp_o       (x_slot_exp_o),
        .consume_i        (consume_x_slot_i),
        .consume_err_o    (x_err)
    );

    redmule_mx_slot #(
        .DATA_W (MX_DATA_W),
        .EXP_W  (MX_EXP_VECTOR_W)
    ) i_w_slot (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clear_i          (clear_i),
        .enable_i         (mx_enable_i),
        .val_valid_i      (w_val_valid_i),
        .val_ready_o      (w_val_ready_o),
        .val_data_i       (w_val_data_i),
        .exp_valid_i      (w_exp_valid_i),
        .exp_ready_o      (w_exp_ready_o),
        .exp_data_i       (w_exp_data_i),
        .slot_valid_o     (w_slot_valid_o),
        .slot_exp_valid_o (w_slot_exp_valid_o),
        .slot_data_o      (w_slot_data_o),
        .slot_exp_o       (w_slot_exp_o),
        .consume_i        (consume_w_slot_i),
        .consume_err_o    (w_err)
    );

    assign consume_err_o = x_err | w_err;

endmodule

// File: tb/tb_redmule_mx_slot_buffer.sv
// Directed bench for redmule_mx_slot_buffer; expectations adapt to REDMULE_MX_SLOT_REFILL_EN.
module tb_redmule_mx_slot_buffer;

    localparam int DW = 256;
    localparam int EW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          mx_enable_i;
    logic          x_val_valid_i;
    logic          x_val_ready_o;
    logic [DW-1:0] x_val_data_i;
    logic          x_exp_valid_i;
    logic          x_exp_ready_o;
    logic [7:0]    x_exp_data_i;
    logic          w_val_valid_i;
    logic          w_val_ready_o;
    logic [DW-1:0] w_val_data_i;
    logic          w_exp_valid_i;
    logic          w_exp_ready_o;
    logic [EW-1:0] w_exp_data_i;
    logic          x_slot_valid_o;
    logic          x_slot_exp_valid_o;
    logic [DW-1:0] x_slot_data_o;
    logic [7:0]    x_slot_exp_o;
    logic          w_slot_valid_o;
    logic          w_slot_exp_valid_o;
    logic [DW-1:0] w_slot_data_o;
    logic [EW-1:0] w_slot_exp_o;
    logic          consume_x_slot_i;
    logic          consume_w_slot_i;
    logic          consume_err_o;

    int checks = 0;
    int errors = 0;

    logic [3:0] rdy;
    logic [3:0] vld;
    assign rdy = {x_val_ready_o, x_exp_ready_o, w_val_ready_o, w_exp_ready_o};
    assign vld = {x_slot_valid_o, x_slot_exp_valid_o, w_slot_valid_o, w_slot_exp_valid_o};

    redmule_mx_slot_buffer #(.MX_DATA_W(DW), .MX_EXP_VECTOR_W(EW)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .clear_i            (clear_i),
        .mx_enable_i        (mx_enable_i),
        .x_val_valid_i      (x_val_valid_i),
        .x_val_ready_o      (x_val_ready_o),
        .x_val_data_i       (x_val_data_i),
        .x_exp_valid_i      (x_exp_valid_i),
        .x_exp_ready_o      (x_exp_ready_o),
        .x_exp_data_i       (x_exp_data_i),
        .w_val_valid_i      (w_val_valid_i),
        .w_val_ready_o      (w_val_ready_o),
        .w_val_data_i       (w_val_data_i),
        .w_exp_valid_i      (w_exp_valid_i),
        .w_exp_ready_o      (w_exp_ready_o),
        .w_exp_data_i       (w_exp_data_i),
        .x_slot_valid_o     (x_slot_valid_o),
        .x_slot_exp_valid_o (x_slot_exp_valid_o),
        .x_slot_data_o      (x_slot_data_o),
        .x_slot_exp_o       (x_slot_exp_o),
        .w_slot_valid_o     (w_slot_valid_o),
        .w_slot_exp_valid_o (w_slot_exp_valid_o),
        .w_slot_data_o      (w_slot_data_o),
        .w_slot_exp_o       (w_slot_exp_o),
        .consume_x_slot_i   (consume_x_slot_i),
        .consume_w_slot_i   (consume_w_slot_i),
        .consume_err_o      (consume_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] xval(int i);
        return {8{32'h5A00_0000 ^ 32'(i)}};
    endfunction
    function automatic logic [7:0] xexp(int i);
        return 8'(i + 16);
    endfunction
    function automatic logic [DW-1:0] wval(int i);
        return {8{32'hC300_0000 ^ 32'(i * 3)}};
    endfunction
    function automatic logic [EW-1:0] wexp(int i);
        return 32'hE000_0000 + 32'(i);
    endfunction

    task automatic drive_idle();
        clear_i = 0; x_val_valid_i = 0; x_exp_valid_i = 0;
        w_val_valid_i = 0; w_exp_valid_i = 0;
        consume_x_slot_i = 0; consume_w_slot_i = 0;
        x_val_data_i = '0; x_exp_data_i = '0; w_val_data_i = '0; w_exp_data_i = '0;
    endtask

    task automatic do_clear();
        @(negedge clk_i); drive_idle(); clear_i = 1;
        @(negedge clk_i); clear_i = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_ni = 0; mx_enable_i = 1;
        x_val_valid_i = 1; x_exp_valid_i = 1; w_val_valid_i = 1; w_exp_valid_i = 1;
        x_val_data_i = {32{8'hFF}};
        @(negedge clk_i); @(negedge clk_i);
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", rdy); end
        checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL reset_valid got %b want 0000", vld); end
        checks++; if (x_slot_data_o !== '0) begin errors++; $display("FAIL reset_xdata got %h want 0", x_slot_data_o); end
        drive_idle(); rst_ni = 1; #1;
        checks++; if (rdy !== 4'b1111) begin errors++; $display("FAIL post_reset_ready got %b want 1111", rdy); end
        checks++; if (consume_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", consume_err_o); end
    endtask

    task automatic test_x_fill();
        logic [DW-1:0] a5;
        a5 = {32{8'hA5}};
        @(negedge clk_i); x_val_valid_i = 1; x_val_data_i = a5;
        @(negedge clk_i); x_val_valid_i = 0; x_val_data_i = '0;
        checks++; if ({x_slot_valid_o, x_slot_exp_valid_o} !== 2'b10) begin errors++; $display("FAIL xfill_t1_valid got %b want 10", {x_slot_valid_o, x_slot_exp_valid_o}); end
        checks++; if (x_slot_data_o !== a5) begin errors++; $display("FAIL xfill_data got %h want %h", x_slot_data_o, a5); end
        checks++; if (x_val_ready_o !== 1'b0) begin errors++; $display("FAIL xfill_val_ready got %b want 0", x_val_ready_o); end
        @(negedge clk_i); x_exp_valid_i = 1; x_exp_data_i = 8'h7F;
        @(negedge clk_i); x_exp_valid_i = 0; x_exp_data_i = 8'h00;
        checks++; if ({x_slot_valid_o, x_slot_exp_valid_o} !== 2'b11) begin errors++; $display("FAIL xfill_t3_valid got %b want 11", {x_slot_valid_o, x_slot_exp_valid_o}); end
        checks++; if (x_slot_exp_o !== 8'h7F) begin errors++; $display("FAIL xfill_exp got %h want 7f", x_slot_exp_o); end
        checks++; if ({x_val_ready_o, x_exp_ready_o} !== 2'b00) begin errors++; $display("FAIL xfill_held_ready got %b want 00", {x_val_ready_o, x_exp_ready_o}); end
        @(negedge clk_i);
        checks++; if (x_slot_data_o !== a5) begin errors++; $display("FAIL xfill_stable got %h want %h", x_slot_data_o, a5); end
        consume_x_slot_i = 1;
        @(negedge clk_i); consume_x_slot_i = 0;
        checks++; if ({x_slot_valid_o, x_slot_exp_valid_o, x_val_ready_o} !== 3'b001) begin errors++; $display("FAIL xfill_consume got %b want 001", {x_slot_valid_o, x_slot_exp_valid_o, x_val_ready_o}); end
        checks++; if (consume_err_o !== 1'b0) begin errors++; $display("FAIL xfill_err got %b want 0", consume_err_o); end
    endtask

    task automatic test_w_same_cycle();
        @(negedge clk_i);
        w_val_valid_i = 1; w_val_data_i = wval(100); w_exp_valid_i = 1; w_exp_data_i = 32'h1234_5678;
        @(negedge clk_i); w_val_valid_i = 0; w_exp_valid_i = 0;
        checks++; if ({w_slot_valid_o, w_slot_exp_valid_o} !== 2'b11) begin errors++; $display("FAIL w_full got %b want 11", {w_slot_valid_o, w_slot_exp_valid_o}); end
        checks++; if (w_slot_exp_o !== 32'h1234_5678) begin errors++; $display("FAIL w_exp got %h want 12345678", w_slot_exp_o); end
        checks++; if (w_slot_data_o !== wval(100)) begin errors++; $display("FAIL w_data got %h want %h", w_slot_data_o, wval(100)); end
        consume_w_slot_i = 1;
`ifdef REDMULE_MX_SLOT_REFILL_EN
        w_val_valid_i = 1; w_val_data_i = wval(101);
        #1;
        checks++; if (w_val_ready_o !== 1'b1) begin errors++; $display("FAIL w_refill_ready got %b want 1", w_val_ready_o); end
        @(negedge clk_i); consume_w_slot_i = 0; w_val_valid_i = 0;
        checks++; if ({w_slot_valid_o, w_slot_exp_valid_o} !== 2'b10) begin errors++; $display("FAIL w_refill_valid got %b want 10", {w_slot_valid_o, w_slot_exp_valid_o}); end
        checks++; if (w_slot_data_o !== wval(101)) begin errors++; $display("FAIL w_refill_data got %h want %h", w_slot_data_o, wval(101)); end
`else
        #1;
        checks++; if (w_val_ready_o !== 1'b0) begin errors++; $display("FAIL w_consume_ready got %b want 0", w_val_ready_o); end
        @(negedge clk_i); consume_w_slot_i = 0;
        checks++; if ({w_slot_valid_o, w_slot_exp_valid_o} !== 2'b00) begin errors++; $display("FAIL w_empty got %b want 00", {w_slot_valid_o, w_slot_exp_valid_o}); end
        checks++; if (w_val_ready_o !== 1'b1) begin errors++; $display("FAIL w_ready_back got %b want 1", w_val_ready_o); end
`endif
        checks++; if (consume_err_o !== 1'b0) begin errors++; $display("FAIL w_err got %b want 0", consume_err_o); end
        do_clear();
    endtask

    task automatic test_consume_err();
        @(negedge clk_i); x_val_valid_i = 1; x_val_data_i = xval(33);
        @(negedge clk_i); x_val_valid_i = 0; consume_x_slot_i = 1;
        @(negedge clk_i); consume_x_slot_i = 0;
        checks++; if ({x_slot_valid_o, x_slot_exp_valid_o} !== 2'b10) begin errors++; $display("FAIL err_slot_kept got %b want 10", {x_slot_valid_o, x_slot_exp_valid_o}); end
        checks++; if (x_slot_data_o !== xval(33)) begin errors++; $display("FAIL err_data_kept got %h want %h", x_slot_data_o, xval(33)); end
        checks++; if (consume_err_o !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", consume_err_o); end
        @(negedge clk_i); @(negedge clk_i);
        checks++; if (consume_err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", consume_err_o); end
        clear_i = 1;
        @(negedge clk_i); clear_i = 0;
        checks++; if (consume_err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", consume_err_o); end
        checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL clear_valid got %b want 0000", vld); end
        checks++; if (x_slot_data_o !== '0) begin errors++; $display("FAIL clear_data got %h want 0", x_slot_data_o); end
    endtask

    task automatic test_enable();
        @(negedge clk_i);
        mx_enable_i = 0;
        x_val_valid_i = 1; x_val_data_i = xval(7); x_exp_valid_i = 1; x_exp_data_i = 8'h3C;
        w_val_valid_i = 1; w_val_data_i = wval(7); w_exp_valid_i = 1; w_exp_data_i = wexp(7);
        #1;
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL dis_ready got %b want 0000", rdy); end
        @(negedge clk_i);
        checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL dis_nocapture got %b want 0000", vld); end
        mx_enable_i = 1; #1;
        checks++; if (rdy !== 4'b1111) begin errors++; $display("FAIL en_ready got %b want 1111", rdy); end
        @(negedge clk_i); drive_idle();
        checks++; if (vld !== 4'b1111) begin errors++; $display("FAIL en_capture got %b want 1111", vld); end
        checks++; if (x_slot_exp_o !== 8'h3C || w_slot_exp_o !== wexp(7)) begin errors++; $display("FAIL en_exps got %h/%h want 3c/%h", x_slot_exp_o, w_slot_exp_o, wexp(7)); end
        mx_enable_i = 0;
        @(negedge clk_i); @(negedge clk_i);
        checks++; if (vld !== 4'b1111 || x_slot_data_o !== xval(7)) begin errors++; $display("FAIL dis_persist got %b/%h want 1111/%h", vld, x_slot_data_o, xval(7)); end
        mx_enable_i = 1;
        do_clear();
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        x_exp_valid_i = 1; x_exp_data_i = 8'h42;
        w_val_valid_i = 1; w_val_data_i = wval(9); w_exp_valid_i = 1; w_exp_data_i = wexp(9);
        @(negedge clk_i); drive_idle();
        checks++; if (vld !== 4'b0111) begin errors++; $display("FAIL mid_state got %b want 0111", vld); end
        #2 rst_ni = 0;
        #1;
        checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL mid_rst_valid got %b want 0000", vld); end
        checks++; if (x_slot_exp_o !== 8'h00 || w_slot_exp_o !== '0 || w_slot_data_o !== '0) begin errors++; $display("FAIL mid_rst_data got %h/%h/%h want 0", x_slot_exp_o, w_slot_exp_o, w_slot_data_o); end
        checks++; if (rdy !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b want 0000", rdy); end
        @(negedge clk_i); rst_ni = 1;
    endtask

    task automatic test_random();
        int n = 40;
        int xv = 0, xe = 0, xc = 0, wv = 0, we = 0, wc = 0;
        bit fxv = 0, fxe = 0, fwv = 0, fwe = 0;
        for (int cyc = 0; cyc < 3000 && (xc < n || wc < n); cyc++) begin
            @(negedge clk_i);
            if (fxv) x_val_valid_i = 0;
            if (fxe) x_exp_valid_i = 0;
            if (fwv) w_val_valid_i = 0;
            if (fwe) w_exp_valid_i = 0;
            consume_x_slot_i = 0; consume_w_slot_i = 0;
            if (x_slot_valid_o && x_slot_exp_valid_o && $urandom_range(0, 2) != 0) begin
                checks++;
                if (x_slot_data_o !== xval(xc) || x_slot_exp_o !== xexp(xc)) begin
                    errors++; $display("FAIL rand_x_%0d got %h/%h want %h/%h", xc, x_slot_data_o[31:0], x_slot_exp_o, xval(xc) & 256'hFFFF_FFFF, xexp(xc));
                end
                xc++; consume_x_slot_i = 1;
            end
            if (w_slot_valid_o && w_slot_exp_valid_o && $urandom_range(0, 2) != 0) begin
                checks++;
                if (w_slot_data_o !== wval(wc) || w_slot_exp_o !== wexp(wc)) begin
                    errors++; $display("FAIL rand_w_%0d got %h/%h want %h/%h", wc, w_slot_data_o[31:0], w_slot_exp_o, wval(wc) & 256'hFFFF_FFFF, wexp(wc));
                end
                wc++; consume_w_slot_i = 1;
            end
            if (!x_val_valid_i && xv < n && $urandom_range(0, 1) == 1) begin x_val_valid_i = 1; x_val_data_i = xval(xv); end
            if (!x_exp_valid_i && xe < n && $urandom_range(0, 1) == 1) begin x_exp_valid_i = 1; x_exp_data_i = xexp(xe); end
            if (!w_val_valid_i && wv < n && $urandom_range(0, 1) == 1) begin w_val_valid_i = 1; w_val_data_i = wval(wv); end
            if (!w_exp_valid_i && we < n && $urandom_range(0, 1) == 1) begin w_exp_valid_i = 1; w_exp_data_i = wexp(we); end
            #1;
            fxv = x_val_valid_i && x_val_ready_o; if (fxv) xv++;
            fxe = x_exp_valid_i && x_exp_ready_o; if (fxe) xe++;
            fwv = w_val_valid_i && w_val_ready_o; if (fwv) wv++;
            fwe = w_exp_valid_i && w_exp_ready_o; if (fwe) we++;
        end
        @(negedge clk_i); drive_idle();
        checks++; if (xc !== n || wc !== n) begin errors++; $display("FAIL rand_delivered got x=%0d w=%0d want %0d", xc, wc, n); end
        checks++; if (vld !== 4'b0000) begin errors++; $display("FAIL rand_drained got %b want 0000", vld); end
        checks++; if (consume_err_o !== 1'b0) begin errors++; $display("FAIL rand_err got %b want 0", consume_err_o); end
    endtask

    initial begin
        test_reset();
        test_x_fill();
        test_w_same_cycle();
        test_consume_err();
        test_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
